// File: rtl/dvl_hw_scb_pkg.sv
// ----------------------------------------------------------------------------
// dvl_hw_pkg
//   Shared types and helpers for the hardware scoreboard (dvl_hw_scb).
//   - scb_state_t : scoreboard FSM states
//   - STOP_ON_ERR : when 1, the first error moves the FSM from RUN to HALT
//   - sat_add     : saturating add used by the statistics counters
// ----------------------------------------------------------------------------
package dvl_hw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } scb_state_t;

  localparam bit STOP_ON_ERR = 1'b1;

  // Returns min(a + b, max). Operands are zero-extended by the caller, so any
  // counter width up to 32 bits can share this one helper.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/dvl_hw_scb_if.sv
// ----------------------------------------------------------------------------
// dvl_hw_scb_if
//   Per-channel valid/ready streams of the hardware scoreboard.
//   exp_* : expected words from the generator (channel c at [c*DW +: DW])
//   act_* : DUT output words to be checked
//   master : stimulus side (drives valid/data, observes ready)
//   slave  : scoreboard side (observes valid/data, drives ready)
// ----------------------------------------------------------------------------
interface dvl_hw_scb_if #(
  parameter int CH = 2,
  parameter int DW = 32
);

  logic [CH-1:0]    exp_valid;
  logic [CH-1:0]    exp_ready;
  logic [CH*DW-1:0] exp_data;
  logic [CH-1:0]    act_valid;
  logic [CH-1:0]    act_ready;
  logic [CH*DW-1:0] act_data;

  modport master (
    output exp_valid, exp_data, act_valid, act_data,
    input  exp_ready, act_ready
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data,
    output exp_ready, act_ready
  );

endinterface

// File: rtl/dvl_hw_scb_fifo.sv
// ----------------------------------------------------------------------------
// dvl_hw_fifo
//   Synchronous FIFO holding the expected words of one scoreboard channel.
//   Ports:
//     clk, resetn    clock, synchronous active-low reset
//     clr            synchronous flush
//     push, din      write din when push and not full
//     pop            drop the head word when pop and not empty
//     full, empty    status
//     head           oldest stored word (valid only when !empty)
//   Pointers carry one extra bit so full/empty are told apart with a natural
//   wrap modulo 2*DEPTH.
// ----------------------------------------------------------------------------
module dvl_hw_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dvl_hw_scb.sv
// ----------------------------------------------------------------------------
// dvl_hw_scb
//   Multi-channel in-order hardware scoreboard. Each channel buffers expected
//   words in a FIFO; every accepted DUT word is compared with the FIFO head.
//   Ports:
//     clk, resetn   clock, synchronous active-low reset
//     en            IDLE -> RUN
//     clr           synchronous clear of FIFOs, counters, error capture; FSM -> IDLE
//     bus           dvl_hw_scb_if.slave: exp_* and act_* valid/ready streams
//     cmp_mask      compare mask (only with DVL_HW_SCB_MASK_EN defined)
//     match_cnt     total matches, saturating
//     mism_cnt      total mismatches, saturating
//     unexp_cnt     words accepted while the channel FIFO was empty, saturating
//     err           sticky first-error flag
//     err_ch        channel of the first error
//     err_exp       expected word of the first error (0 for an unexpected word)
//     err_act       actual word of the first error
//     done          RUN, all FIFOs empty and no act_valid this cycle
//   Build option: DVL_HW_SCB_MASK_EN adds cmp_mask; a match then only requires
//   the unmasked bits to agree. Captured error words stay unmasked.
//   Compare results are staged one cycle: the FIFO pops at the accept edge and
//   counters/error capture update on the following edge.
// ----------------------------------------------------------------------------
module dvl_hw_scb
  import dvl_hw_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CH    = 2,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic                 clr,
  dvl_hw_scb_if.slave          bus,
`ifdef DVL_HW_SCB_MASK_EN
  input  logic [DW-1:0]        cmp_mask,
`endif
  output logic [CNTW-1:0]      match_cnt,
  output logic [CNTW-1:0]      mism_cnt,
  output logic [CNTW-1:0]      unexp_cnt,
  output logic                 err,
  output logic [$clog2(CH):0]  err_ch,
  output logic [DW-1:0]        err_exp,
  output logic [DW-1:0]        err_act,
  output logic                 done
);

  localparam int          CHW     = $clog2(CH) + 1;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNTW) - 64'd1);

  scb_state_t state_q, state_d;
  logic       running, halted;

  logic [CH-1:0] full, empty, push, pop, acc, same;
  logic [CH-1:0] hit, miss, unexp;
  logic [DW-1:0] head [CH];

  // Staged compare results, applied to the statistics one edge later.
  logic [CH-1:0] r_match, r_mism, r_unexp;
  logic [DW-1:0] r_exp [CH];
  logic [DW-1:0] r_act [CH];
  logic          stage_err;

  logic           first_found;
  logic [CHW-1:0] first_ch;
  logic [DW-1:0]  first_exp, first_act;

  assign running = (state_q == RUN);
  assign halted  = (state_q == HALT);

  // --------------------------------------------------------------------------
  // Per-channel FIFO and compare
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < CH; c++) begin : g_ch
    dvl_hw_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr),
      .push   (push[c]),
      .pop    (pop[c]),
      .din    (bus.exp_data[c*DW +: DW]),
      .full   (full[c]),
      .empty  (empty[c]),
      .head   (head[c])
    );

    // No pop-through: a full FIFO refuses a push even if it pops this cycle.
    assign bus.exp_ready[c] = !halted && !full[c];
    assign bus.act_ready[c] = running;

    assign push[c] = bus.exp_valid[c] && bus.exp_ready[c];
    assign acc[c]  = bus.act_valid[c] && running;
    assign pop[c]  = acc[c] && !empty[c];

`ifdef DVL_HW_SCB_MASK_EN
    assign same[c] = ((bus.act_data[c*DW +: DW] ^ head[c]) & cmp_mask) == '0;
`else
    assign same[c] = (bus.act_data[c*DW +: DW] == head[c]);
`endif

    // A word pushed in the same cycle is not visible yet: empty means unexpected.
    assign hit[c]   = pop[c] && same[c];
    assign miss[c]  = pop[c] && !same[c];
    assign unexp[c] = acc[c] && empty[c];
  end

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      r_match <= '0;
      r_mism  <= '0;
      r_unexp <= '0;
      for (int c = 0; c < CH; c++) begin
        r_exp[c] <= '0;
        r_act[c] <= '0;
      end
    end else begin
      r_match <= hit;
      r_mism  <= miss;
      r_unexp <= unexp;
      for (int c = 0; c < CH; c++) begin
        r_exp[c] <= miss[c] ? head[c] : '0;
        r_act[c] <= bus.act_data[c*DW +: DW];
      end
    end
  end

  assign stage_err = |(r_mism | r_unexp);

  // Lowest-numbered erroring channel of the staged cycle.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    first_exp   = '0;
    first_act   = '0;
    for (int c = 0; c < CH; c++) begin
      if (!first_found && (r_mism[c] || r_unexp[c])) begin
        first_found = 1'b1;
        first_ch    = CHW'(c);
        first_exp   = r_exp[c];
        first_act   = r_act[c];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn || clr) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (STOP_ON_ERR && stage_err) state_d = HALT;
      HALT:    state_d = HALT;  // only clr leaves HALT
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Statistics and first-error capture (frozen outside RUN)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      match_cnt <= '0;
      mism_cnt  <= '0;
      unexp_cnt <= '0;
      err       <= 1'b0;
      err_ch    <= '0;
      err_exp   <= '0;
      err_act   <= '0;
    end else if (running) begin
      match_cnt <= CNTW'(sat_add(32'(match_cnt), 32'($countones(r_match)), CNT_MAX));
      mism_cnt  <= CNTW'(sat_add(32'(mism_cnt),  32'($countones(r_mism)),  CNT_MAX));
      unexp_cnt <= CNTW'(sat_add(32'(unexp_cnt), 32'($countones(r_unexp)), CNT_MAX));
      if (!err && first_found) begin
        err     <= 1'b1;
        err_ch  <= first_ch;
        err_exp <= first_exp;
        err_act <= first_act;
      end
    end
  end

  assign done = running && (&empty) && !(|bus.act_valid);

endmodule

// File: tb/tb_dvl_hw_scb.sv
// ----------------------------------------------------------------------------
// tb_dvl_hw_scb
//   Directed bench for dvl_hw_scb (CH=2, DW=32, DEPTH=8, CNTW=4). A behavioural
//   model tracks the expected FIFOs and statistics; every cycle with accepted
//   DUT words queues the expected statistics, which are compared two edges
//   later when the staged result reaches the outputs.
//   Honours DVL_HW_SCB_MASK_EN (cmp_mask port and masked compare).
// ----------------------------------------------------------------------------
module tb_dvl_hw_scb;
  import dvl_hw_pkg::*;

  localparam int DW    = 32;
  localparam int CH    = 2;
  localparam int DEPTH = 8;
  localparam int CNTW  = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic resetn, en, clr;
  logic [CNTW-1:0] match_cnt, mism_cnt, unexp_cnt;
  logic            err, done;
  logic [1:0]      err_ch;
  logic [DW-1:0]   err_exp, err_act;
`ifdef DVL_HW_SCB_MASK_EN
  logic [DW-1:0]   cmp_mask;
`endif

  dvl_hw_scb_if #(.CH(CH), .DW(DW)) bus ();

  dvl_hw_scb #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .clr       (clr),
    .bus       (bus),
`ifdef DVL_HW_SCB_MASK_EN
    .cmp_mask  (cmp_mask),
`endif
    .match_cnt (match_cnt),
    .mism_cnt  (mism_cnt),
    .unexp_cnt (unexp_cnt),
    .err       (err),
    .err_ch    (err_ch),
    .err_exp   (err_exp),
    .err_act   (err_act),
    .done      (done)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Bookkeeping, model and scoreboard
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    string       tag;
    int          mc, mm, mu;
    logic        e;
    int          ech;
    logic [31:0] eexp, eact;
  } snap_t;

  snap_t sb[$];

  scb_state_t  m_state;
  logic [31:0] m_fifo [CH][DEPTH];
  int          m_rp [CH];
  int          m_n  [CH];
  int          m_match, m_mism, m_unexp, m_ech;
  logic        m_err;
  logic [31:0] m_eexp, m_eact;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = IDLE;
    for (int c = 0; c < CH; c++) begin
      m_rp[c] = 0;
      m_n[c]  = 0;
    end
    m_match = 0; m_mism = 0; m_unexp = 0;
    m_err = 1'b0; m_ech = 0; m_eexp = '0; m_eact = '0;
  endtask

  function automatic int sat(input int a, input int b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  function automatic logic words_match(input logic [31:0] a, input logic [31:0] e);
`ifdef DVL_HW_SCB_MASK_EN
    return ((a ^ e) & cmp_mask) == 32'h0;
`else
    return a == e;
`endif
  endfunction

  // One clock edge; afterwards compare every scoreboard entry now due.
  task automatic tick();
    snap_t s;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      s = sb.pop_front();
      check({s.tag, ".match_cnt"}, 32'(match_cnt), s.mc);
      check({s.tag, ".mism_cnt"},  32'(mism_cnt),  s.mm);
      check({s.tag, ".unexp_cnt"}, 32'(unexp_cnt), s.mu);
      check({s.tag, ".err"},       32'(err),       32'(s.e));
      check({s.tag, ".err_ch"},    32'(err_ch),    s.ech);
      check({s.tag, ".err_exp"},   err_exp,        s.eexp);
      check({s.tag, ".err_act"},   err_act,        s.eact);
    end
  endtask

  // Drive one cycle of exp/act traffic, update the model, queue the outcome.
  task automatic drive(input logic [1:0] ev, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] av, input logic [31:0] a0, input logic [31:0] a1,
                       input string tag);
    logic [31:0] ed [CH];
    logic [31:0] ad [CH];
    logic [31:0] hd;
    logic        push_ok [CH];
    logic        any, new_err;
    snap_t       s;
    ed[0] = e0; ed[1] = e1;
    ad[0] = a0; ad[1] = a1;
    bus.exp_valid = ev;
    bus.exp_data  = {e1, e0};
    bus.act_valid = av;
    bus.act_data  = {a1, a0};
    any = 1'b0;
    new_err = 1'b0;
    for (int c = 0; c < CH; c++)
      push_ok[c] = ev[c] && (m_state != HALT) && (m_n[c] < DEPTH);
    for (int c = 0; c < CH; c++) begin
      if (av[c] && m_state == RUN) begin
        any = 1'b1;
        if (m_n[c] == 0) begin
          m_unexp = sat(m_unexp, 1);
          new_err = 1'b1;
          if (!m_err) begin
            m_err = 1'b1; m_ech = c; m_eexp = '0; m_eact = ad[c];
          end
        end else begin
          hd = m_fifo[c][m_rp[c]];
          m_rp[c] = (m_rp[c] + 1) % DEPTH;
          m_n[c]--;
          if (words_match(ad[c], hd)) begin
            m_match = sat(m_match, 1);
          end else begin
            m_mism = sat(m_mism, 1);
            new_err = 1'b1;
            if (!m_err) begin
              m_err = 1'b1; m_ech = c; m_eexp = hd; m_eact = ad[c];
            end
          end
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (push_ok[c]) begin
        m_fifo[c][(m_rp[c] + m_n[c]) % DEPTH] = ed[c];
        m_n[c]++;
      end
    end
    if (any) begin
      s.due = cyc + 2; s.tag = tag;
      s.mc = m_match; s.mm = m_mism; s.mu = m_unexp;
      s.e = m_err; s.ech = m_ech; s.eexp = m_eexp; s.eact = m_eact;
      sb.push_back(s);
    end
    if (new_err) m_state = HALT;  // takes effect with the staged result
    tick();
    bus.exp_valid = '0;
    bus.act_valid = '0;
  endtask

  task automatic start();
    en = 1'b1;
    tick();
    en = 1'b0;
    if (m_state == IDLE) m_state = RUN;
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_reset();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".match_cnt"}, 32'(match_cnt), 0);
    check({tag, ".mism_cnt"},  32'(mism_cnt),  0);
    check({tag, ".unexp_cnt"}, 32'(unexp_cnt), 0);
    check({tag, ".err"},       32'(err),       0);
    check({tag, ".err_ch"},    32'(err_ch),    0);
    check({tag, ".err_exp"},   err_exp,        0);
    check({tag, ".err_act"},   err_act,        0);
    check({tag, ".exp_ready"}, 32'(bus.exp_ready), 32'h3);
    check({tag, ".act_ready"}, 32'(bus.act_ready), 32'h0);
    check({tag, ".done"},      32'(done),      0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    resetn = 1'b0; en = 1'b0; clr = 1'b0;
    bus.exp_valid = '0; bus.exp_data = '0;
    bus.act_valid = '0; bus.act_data = '0;
`ifdef DVL_HW_SCB_MASK_EN
    cmp_mask = '1;
`endif
    m_reset();

    // Reset state
    tick(); tick();
    check_cleared("reset");
    resetn = 1'b1;

    // Preload ch0 in IDLE, then two in-order matches
    drive(2'b01, 32'hA5, 0, 2'b00, 0, 0, "pre0");
    drive(2'b01, 32'h3C, 0, 2'b00, 0, 0, "pre1");
    check("idle.act_ready", 32'(bus.act_ready), 32'h0);
    check("idle.done", 32'(done), 0);
    start();
    check("run.act_ready", 32'(bus.act_ready), 32'h3);
    check("run.done_pending", 32'(done), 0);
    drive(2'b00, 0, 0, 2'b01, 32'hA5, 0, "m_a5");
    drive(2'b00, 0, 0, 2'b01, 32'h3C, 0, "m_3c");
    tick();
    check("inorder.done", 32'(done), 1);
    check("inorder.match", 32'(match_cnt), 2);

    // ch1 mismatch -> HALT
    drive(2'b10, 0, 32'h10, 2'b00, 0, 0, "pre_ch1");
    drive(2'b00, 0, 0, 2'b10, 0, 32'h11, "mism_ch1");
    tick();
    check("halt.act_ready", 32'(bus.act_ready), 32'h0);
    check("halt.exp_ready", 32'(bus.exp_ready), 32'h0);
    check("halt.done", 32'(done), 0);
    drive(2'b00, 0, 0, 2'b01, 32'h55, 0, "halt_act");
    tick();
    check("halt.freeze_mism", 32'(mism_cnt), m_mism);
    check("halt.freeze_match", 32'(match_cnt), m_match);

    // clr from HALT
    clear();
    check_cleared("clr_halt");

    // Both channels unexpected in one cycle -> lowest channel captured
    start();
    drive(2'b00, 0, 0, 2'b11, 32'hAA, 32'hBB, "unexp_both");
    tick();

    // Push and accept to an empty FIFO in the same cycle -> unexpected
    clear();
    start();
    drive(2'b01, 32'h77, 0, 2'b01, 32'h77, 0, "unexp_bypass");
    tick();
    check("bypass.fifo_holds_word", 32'(dut.g_ch[0].u_fifo.empty), 0);

    // Fill both FIFOs, full flag, then dual matches up to saturation
    clear();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0 || i == DEPTH - 1)
        check("fill.exp_ready", 32'(bus.exp_ready), 32'h3);
      drive(2'b11, 32'h100 + i, 32'h200 + i, 2'b00, 0, 0, "fill");
    end
    check("full.exp_ready", 32'(bus.exp_ready), 32'h0);
    drive(2'b11, 32'hDEAD, 32'hBEEF, 2'b00, 0, 0, "overfill");
    start();
    for (int i = 0; i < DEPTH; i++) begin
      drive(2'b00, 0, 0, 2'b11, 32'h100 + i, 32'h200 + i, "dual");
      if (i == 0) check("pop.exp_ready", 32'(bus.exp_ready), 32'h3);
    end
    tick(); tick();
    check("sat.match_cnt", 32'(match_cnt), CMAX);
    check("drain.done", 32'(done), 1);

    // Masked compare (or full-width mismatch without the mask option)
    clear();
    drive(2'b01, 32'h1234_5600, 0, 2'b00, 0, 0, "mask_pre");
`ifdef DVL_HW_SCB_MASK_EN
    cmp_mask = 32'hFFFF_FF00;
`endif
    start();
    drive(2'b00, 0, 0, 2'b01, 32'h1234_56FF, 0, "mask_cmp");
    tick();
`ifdef DVL_HW_SCB_MASK_EN
    cmp_mask = '1;
`endif

    // clr mid-run with a word still buffered
    clear();
    start();
    drive(2'b10, 0, 32'h42, 2'b00, 0, 0, "midrun_pre");
    check("midrun.done", 32'(done), 0);
    clear();
    check_cleared("clr_midrun");
    start();
    check("after_clr.done", 32'(done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
